wb_host_cmd_sequencer: RTL and testbench
========================================

Name: wb_host_cmd_sequencer

Overview:
Converts one 32-bit host command word (wire-in, qualified by a trigger-in pulse) into single or burst Wishbone classic cycles toward an 8-bit peripheral register file. Read data is packed into 32-bit words and pushed into the host-side readback FIFO, which the host drains through the pipe-out. Write-back stalls on FIFO full, so no read data is lost. Stalled bus cycles are aborted by a timeout, and status is reported back to the host.

Parameters:
ADDR_W, 8, Wishbone address width; also the width of the command address field
DATA_W, 8, Wishbone data width
TIMEOUT, 255, max cycles waiting for wb_ack_i before the command is aborted (1..65535)

Ports:
clk  in  1  okClk domain; single clock
rst  in  1  synchronous, active-high reset (host master-reset trigger bit)
cmd_word  in  32  command: [31:30] op (00 NOP, 01 WRITE, 10 READ, 11 READ_BURST); [29:24] burst count-1; [23:16] reserved; [15:8] addr; [7:0] wdata
cmd_trig  in  1  one-cycle pulse; cmd_word is valid in the same cycle
busy  out  1  high while a command is executing
wb_cyc_o  out  1  Wishbone cycle
wb_stb_o  out  1  Wishbone strobe; always equal to wb_cyc_o
wb_we_o  out  1  write enable
wb_adr_o  out  ADDR_W  address
wb_dat_o  out  DATA_W  write data
wb_dat_i  in  DATA_W  read data
wb_ack_i  in  1  acknowledge
fifo_wr_en  out  1  single-cycle push strobe
fifo_din  out  32  pushed word = {idx[7:0], 8'h00, addr[7:0], rdata[7:0]}
fifo_full  in  1  FIFO full flag
last_write  out  32  copy of the last word pushed
err_timeout  out  1  sticky; set when a cycle times out; cleared only by rst
cmd_dropped  out  1  sticky; set when cmd_trig arrives while busy; cleared only by rst

Behaviour:
- Reset: every output is 0 at the edge after rst is sampled high. Any in-flight cycle is abandoned and cyc/stb drop at that edge.
- FSM states:
  - IDLE -> WB_REQ when cmd_trig is high and op != NOP. cmd_word is latched in the trigger cycle. cyc/stb/busy are high at the next edge (latency 1).
  - NOP and reserved bits are ignored; a NOP leaves busy low.
  - WB_REQ: drives cyc=stb=1, we = (op==WRITE), adr = latched addr, dat_o = wdata.
  - WB_REQ on sampled ack: cyc/stb drop at that edge. A read captures wb_dat_i and goes to PUSH. A write goes to IDLE.
  - WB_REQ without ack: a counter increments each cycle in WB_REQ. When it reaches TIMEOUT, cyc/stb drop, err_timeout is set, the remaining burst is discarded, and the FSM goes to IDLE.
  - PUSH: while fifo_full=1, stay and hold data. When fifo_full=0, assert fifo_wr_en for exactly one cycle with fifo_din, and update last_write in the same cycle.
  - PUSH -> WB_REQ (next beat) if beats remain, otherwise -> IDLE.
- Bursts:
  - READ_BURST issues count+1 reads (1..64) to the same address. idx runs 0..count.
  - READ always uses idx=0 and a single beat.
  - A burst never pushes more than count+1 words.
- Back-to-back commands: busy falls on the edge entering IDLE. A cmd_trig in that IDLE cycle is accepted.
- cmd_trig while busy: the command is ignored and cmd_dropped is set. Execution of the current command is unaffected.
- Simultaneous ack and timeout-terminal count: ack wins, the data is valid, and err_timeout is not set.
- The timeout counter clears on every entry to WB_REQ.
- Widths: idx is zero-extended from 6 to 8 bits. Addr is zero-extended into the 8-bit field when ADDR_W < 8.

Decomposition:
- Shared package wb_host_pkg holds:
  - op codes (OP_NOP, OP_WRITE, OP_READ, OP_BURST)
  - command field bit positions
  - FSM state enum
  - FIFO word field positions
- The top module of the user HDL uses the same package to decode.
- Optional sub-module wb_timeout_ctr (load/enable/terminal-count counter).
- FSM, datapath and packing stay in this module.

Test Plan:
- WRITE: cmd 0x4000_2A5C + trig -> one cycle later cyc=stb=we=1, adr=0x2A, dat_o=0x5C. With ack after 3 cycles, cyc drops the same edge, no fifo_wr_en, busy low.
- READ: cmd 0x8000_1100, slave returns 0x7E with ack -> exactly one push of 0x0000_117E, last_write=0x0000_117E.
- READ_BURST count-1=3 at addr 0x05, data 0x10..0x13 -> 4 pushes 0x0000_0510, 0x0100_0511, 0x0200_0512, 0x0300_0513.
- Backpressure: fifo_full held high 20 cycles during a burst -> no push while full, no lost or duplicated words, fifo_wr_en is single-cycle each time.
- Timeout: TIMEOUT=16, no ack -> cyc drops after 16 cycles in WB_REQ, err_timeout=1, remaining beats not issued, next command executes normally.
- Trigger while busy plus reset mid-burst -> cmd_dropped=1 with the original command completing. rst asserted in the middle of the next burst -> all outputs 0 next edge, sticky flags cleared.

Source files
------------

// File: rtl/wb_host_pkg.sv
// Shared definitions for the host command sequencer: opcodes, command/FIFO word layout, FSM states.
package wb_host_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_BURST = 2'b11
  } op_e;

  localparam int unsigned CmdOpHi  = 31;
  localparam int unsigned CmdOpLo  = 30;
  localparam int unsigned CmdCntHi = 29;
  localparam int unsigned CmdCntLo = 24;
  localparam int unsigned CmdAdrHi = 15;
  localparam int unsigned CmdAdrLo = 8;
  localparam int unsigned CmdDatHi = 7;
  localparam int unsigned CmdDatLo = 0;

  localparam int unsigned FifoIdxLo = 24;
  localparam int unsigned FifoAdrLo = 8;
  localparam int unsigned FifoDatLo = 0;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StPush
  } state_e;

  // Readback word: {idx (zero-extended), 8'h00, addr, rdata}
  function automatic logic [31:0] pack_fifo_word(logic [5:0] idx, logic [7:0] adr,
                                                 logic [7:0] dat);
    return ({26'd0, idx} << FifoIdxLo) | ({24'd0, adr} << FifoAdrLo) |
           ({24'd0, dat} << FifoDatLo);
  endfunction

endpackage

// File: rtl/wb_timeout_ctr.sv
// Bus-cycle watchdog: clears while idle, counts while enabled, flags the final allowed cycle.
module wb_timeout_ctr #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [15:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  // Terminal on the TIMEOUT-th waiting cycle so the strobe is held exactly TIMEOUT cycles
  assign tc_o = en_i && (cnt_q == 16'(TIMEOUT - 1));

endmodule

// File: rtl/wb_host_cmd_sequencer.sv
// Turns a host command word into single/burst Wishbone cycles and packs read data into the FIFO.
module wb_host_cmd_sequencer
  import wb_host_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       cmd_word,
  input  logic              cmd_trig,
  output logic              busy,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [DATA_W-1:0] wb_dat_o,
  input  logic [DATA_W-1:0] wb_dat_i,
  input  logic              wb_ack_i,
  output logic              fifo_wr_en,
  output logic [31:0]       fifo_din,
  input  logic              fifo_full,
  output logic [31:0]       last_write,
  output logic              err_timeout,
  output logic              cmd_dropped
);

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] wdat_q, wdat_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [5:0]        idx_q, idx_d;
  logic [31:0]       last_q, last_d;
  logic              err_q, err_d;
  logic              drop_q, drop_d;
  logic              tmo_tc;
  op_e               cmd_op;

  assign cmd_op = op_e'(cmd_word[CmdOpHi:CmdOpLo]);

  wb_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout_ctr (
    .clk_i(clk),
    .rst_i(rst),
    .clr_i(state_q != StReq),
    .en_i (state_q == StReq),
    .tc_o (tmo_tc)
  );

  assign fifo_din = pack_fifo_word(idx_q, 8'(adr_q), 8'(rdata_q));

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    adr_d      = adr_q;
    wdat_d     = wdat_q;
    rdata_d    = rdata_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    last_d     = last_q;
    err_d      = err_q;
    drop_d     = drop_q;
    fifo_wr_en = 1'b0;

    if (cmd_trig && (state_q != StIdle)) begin
      drop_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (cmd_trig && (cmd_op != OP_NOP)) begin
          state_d = StReq;
          we_d    = (cmd_op == OP_WRITE);
          adr_d   = ADDR_W'(cmd_word[CmdAdrHi:CmdAdrLo]);
          wdat_d  = DATA_W'(cmd_word[CmdDatHi:CmdDatLo]);
          cnt_d   = (cmd_op == OP_BURST) ? cmd_word[CmdCntHi:CmdCntLo] : 6'd0;
          idx_d   = 6'd0;
        end
      end
      StReq: begin
        // Ack takes priority over a timeout landing on the same cycle
        if (wb_ack_i) begin
          if (we_q) begin
            state_d = StIdle;
          end else begin
            rdata_d = wb_dat_i;
            state_d = StPush;
          end
        end else if (tmo_tc) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StPush: begin
        if (!fifo_full) begin
          fifo_wr_en = 1'b1;
          last_d     = fifo_din;
          if (idx_q == cnt_q) begin
            state_d = StIdle;
          end else begin
            idx_d   = idx_q + 6'd1;
            state_d = StReq;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      adr_q   <= '0;
      wdat_q  <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      last_q  <= '0;
      err_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign wb_cyc_o    = (state_q == StReq);
  assign wb_stb_o    = wb_cyc_o;
  assign wb_we_o     = wb_cyc_o && we_q;
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = wdat_q;
  assign last_write  = last_q;
  assign err_timeout = err_q;
  assign cmd_dropped = drop_q;

endmodule

// File: tb/tb_wb_host_cmd_sequencer.sv
// Randomized bench for wb_host_cmd_sequencer with a Wishbone slave model and FIFO scoreboard.
module tb_wb_host_cmd_sequencer;

  localparam int unsigned TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cmd_word;
  logic        cmd_trig;
  logic        busy;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [7:0]  wb_adr_o, wb_dat_o, wb_dat_i;
  logic        wb_ack_i;
  logic        fifo_wr_en;
  logic [31:0] fifo_din;
  logic        fifo_full;
  logic [31:0] last_write;
  logic        err_timeout, cmd_dropped;

  always #5 clk = ~clk;

  wb_host_cmd_sequencer #(
    .ADDR_W (8),
    .DATA_W (8),
    .TIMEOUT(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_word   (cmd_word),
    .cmd_trig   (cmd_trig),
    .busy       (busy),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_we_o    (wb_we_o),
    .wb_adr_o   (wb_adr_o),
    .wb_dat_o   (wb_dat_o),
    .wb_dat_i   (wb_dat_i),
    .wb_ack_i   (wb_ack_i),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .fifo_full  (fifo_full),
    .last_write (last_write),
    .err_timeout(err_timeout),
    .cmd_dropped(cmd_dropped)
  );

  int          tests = 0;
  int          fails = 0;
  int          ack_fixed = 0;  // >=0 fixed wait cycles, -1 random 0..4, -2 never ack
  logic [31:0] pushed[$];
  logic [31:0] exp_q[$];
  logic [7:0]  data_q[$];
  logic [7:0]  rd_log[$];
  logic [15:0] wr_log[$];
  int          push_full_err = 0;
  int          dbl_err = 0;

  // FIFO-side monitor, sampled mid-cycle
  initial begin
    logic prev_wr;
    prev_wr = 1'b0;
    forever begin
      @(negedge clk);
      if (fifo_wr_en) begin
        pushed.push_back(fifo_din);
        if (fifo_full) push_full_err++;
        if (prev_wr) dbl_err++;
      end
      prev_wr = fifo_wr_en;
    end
  end

  // Wishbone slave: acks after a chosen number of wait cycles and logs every transfer
  initial begin
    int wait_cnt;
    int delay;
    wait_cnt = 0;
    delay    = 0;
    wb_ack_i = 1'b0;
    wb_dat_i = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      wb_ack_i = 1'b0;
      if (wb_cyc_o) begin
        if (wait_cnt == 0) begin
          if (ack_fixed >= 0) delay = ack_fixed;
          else if (ack_fixed == -1) delay = int'($urandom_range(0, 4));
          else delay = 1000000;
        end
        if (wait_cnt == delay) begin
          wb_ack_i = 1'b1;
          if (data_q.size() > 0) wb_dat_i = data_q.pop_front();
          else wb_dat_i = 8'($urandom);
          if (wb_we_o) wr_log.push_back({wb_adr_o, wb_dat_o});
          else rd_log.push_back(wb_dat_i);
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] w);
    cmd_word = w;
    cmd_trig = 1'b1;
    step();
    cmd_trig = 1'b0;
    cmd_word = $urandom;
  endtask

  task automatic wait_idle(input int budget, input bit rand_full, output int n);
    n = 0;
    while (busy && n < budget) begin
      if (rand_full) fifo_full = ($urandom_range(0, 2) == 0);
      step();
      n++;
    end
    fifo_full = 1'b0;
    if (busy) n = -1;
  endtask

  task automatic clear_logs();
    pushed.delete();
    exp_q.delete();
    data_q.delete();
    rd_log.delete();
    wr_log.delete();
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    cmd_trig  = 1'b0;
    fifo_full = 1'b0;
    step();
    rst = 1'b0;
  endtask

  // Reference: each completed read beat i yields {i, 8'h00, addr, data returned on beat i}
  function automatic void build_expect(input logic [1:0] op, input logic [5:0] cm1,
                                       input logic [7:0] adr);
    int beats;
    exp_q.delete();
    beats = (op == 2'b10) ? 1 : (op == 2'b11) ? int'(cm1) + 1 : 0;
    for (int i = 0; i < beats; i++) begin
      exp_q.push_back({8'(i), 8'h00, adr, rd_log[i]});
    end
  endfunction

  function automatic int count_diff();
    int d;
    d = (pushed.size() > exp_q.size()) ? pushed.size() - exp_q.size()
                                       : exp_q.size() - pushed.size();
    for (int i = 0; i < pushed.size() && i < exp_q.size(); i++) begin
      if (pushed[i] !== exp_q[i]) d++;
    end
    return d;
  endfunction

  task automatic test_reset();
    rst      = 1'b1;
    cmd_word = 32'h4000_2A5C;
    cmd_trig = 1'b1;
    fifo_full = 1'b0;
    step();
    step();
    rst      = 1'b0;
    cmd_trig = 1'b0;
    tests++;
    if ({busy, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, fifo_wr_en, err_timeout,
         cmd_dropped} !== '0) begin
      fails++;
      $display("FAIL reset_ctrl: got busy=%b cyc=%b stb=%b we=%b adr=%h dat=%h wr=%b err=%b drop=%b, expected all 0",
               busy, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, fifo_wr_en,
               err_timeout, cmd_dropped);
    end
    tests++;
    if (fifo_din !== 32'h0 || last_write !== 32'h0) begin
      fails++;
      $display("FAIL reset_data: got din=%h last=%h, expected 0", fifo_din, last_write);
    end
  endtask

  task automatic test_write();
    clear_logs();
    ack_fixed = 2;
    issue(32'h4000_2A5C);
    tests++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, busy, wb_adr_o, wb_dat_o} !== {4'b1111, 8'h2A, 8'h5C}) begin
      fails++;
      $display("FAIL write_drive: got cyc=%b stb=%b we=%b busy=%b adr=%h dat=%h, expected 1 1 1 1 2a 5c",
               wb_cyc_o, wb_stb_o, wb_we_o, busy, wb_adr_o, wb_dat_o);
    end
    step();
    step();
    tests++;
    if (wb_cyc_o !== 1'b1) begin
      fails++;
      $display("FAIL write_hold: got cyc=%b, expected 1 before ack", wb_cyc_o);
    end
    step();
    tests++;
    if ({wb_cyc_o, busy} !== 2'b00) begin
      fails++;
      $display("FAIL write_end: got cyc=%b busy=%b, expected 0 0", wb_cyc_o, busy);
    end
    tests++;
    if (pushed.size() != 0 || wr_log.size() != 1 || wr_log[0] !== 16'h2A5C) begin
      fails++;
      $display("FAIL write_log: got pushes=%0d writes=%0d first=%h, expected 0 1 2a5c",
               pushed.size(), wr_log.size(), wr_log[0]);
    end
  endtask

  task automatic test_read();
    int n;
    clear_logs();
    ack_fixed = 0;
    data_q.push_back(8'h7E);
    issue(32'h8000_1100);
    wait_idle(50, 1'b0, n);
    tests++;
    if (n < 0 || pushed.size() != 1 || pushed[0] !== 32'h0000_117E) begin
      fails++;
      $display("FAIL read_push: got n=%0d pushes=%0d word=%h, expected 1 push of 0000117e",
               n, pushed.size(), pushed[0]);
    end
    tests++;
    if (last_write !== 32'h0000_117E) begin
      fails++;
      $display("FAIL read_last: got %h expected 0000117e", last_write);
    end
  endtask

  task automatic test_burst();
    int n;
    int d;
    clear_logs();
    ack_fixed = -1;
    data_q = '{8'h10, 8'h11, 8'h12, 8'h13};
    issue(32'hC300_0500);
    wait_idle(200, 1'b0, n);
    exp_q = '{32'h0000_0510, 32'h0100_0511, 32'h0200_0512, 32'h0300_0513};
    d = count_diff();
    tests++;
    if (n < 0 || d != 0) begin
      fails++;
      $display("FAIL burst_words: got n=%0d pushes=%0d diffs=%0d last=%h, expected 4 pushes ending 03000513",
               n, pushed.size(), d, last_write);
    end
  endtask

  task automatic test_backpressure();
    int n;
    int d;
    logic [5:0] cm1;
    logic [7:0] adr;
    clear_logs();
    ack_fixed = -1;
    cm1 = 6'($urandom_range(4, 10));
    adr = 8'($urandom);
    issue({2'b11, cm1, 8'($urandom), adr, 8'($urandom)});
    fifo_full = 1'b1;
    repeat (20) step();
    tests++;
    if (pushed.size() != 0) begin
      fails++;
      $display("FAIL bp_hold: got %0d pushes while full, expected 0", pushed.size());
    end
    fifo_full = 1'b0;
    wait_idle(600, 1'b1, n);
    build_expect(2'b11, cm1, adr);
    d = count_diff();
    tests++;
    if (n < 0 || d != 0) begin
      fails++;
      $display("FAIL bp_words: got n=%0d pushes=%0d diffs=%0d, expected %0d pushes",
               n, pushed.size(), d, exp_q.size());
    end
    tests++;
    if (push_full_err != 0 || dbl_err != 0) begin
      fails++;
      $display("FAIL bp_strobe: got push_while_full=%0d double=%0d, expected 0 0",
               push_full_err, dbl_err);
    end
  endtask

  task automatic test_random();
    int n;
    int d;
    logic [1:0] op;
    logic [5:0] cm1;
    logic [7:0] adr, wd;
    for (int it = 0; it < 12; it++) begin
      clear_logs();
      ack_fixed = -1;
      op  = 2'($urandom_range(0, 3));
      cm1 = 6'($urandom_range(0, 7));
      adr = 8'($urandom);
      wd  = 8'($urandom);
      issue({op, cm1, 8'($urandom), adr, wd});
      if (op == 2'b00) begin
        tests++;
        if ({busy, wb_cyc_o} !== 2'b00) begin
          fails++;
          $display("FAIL rand_nop: got busy=%b cyc=%b, expected 0 0", busy, wb_cyc_o);
        end
      end else begin
        wait_idle(600, 1'b1, n);
        build_expect(op, cm1, adr);
        d = count_diff();
        tests++;
        if (n < 0 || d != 0) begin
          fails++;
          $display("FAIL rand_cmd op=%0d: got n=%0d pushes=%0d diffs=%0d, expected %0d pushes",
                   op, n, pushed.size(), d, exp_q.size());
        end
        if (op == 2'b01) begin
          tests++;
          if (wr_log.size() != 1 || wr_log[0] !== {adr, wd}) begin
            fails++;
            $display("FAIL rand_write: got writes=%0d first=%h, expected 1 %h",
                     wr_log.size(), wr_log[0], {adr, wd});
          end
        end
      end
    end
  endtask

  task automatic test_timeout();
    int n;
    int extra;
    clear_logs();
    ack_fixed = -2;
    issue(32'hC500_3300);
    n = 0;
    while (wb_cyc_o && n < 100) begin
      n++;
      step();
    end
    tests++;
    if (n != int'(TMO)) begin
      fails++;
      $display("FAIL tmo_len: got cyc high %0d cycles, expected %0d", n, TMO);
    end
    tests++;
    if ({err_timeout, busy} !== 2'b10) begin
      fails++;
      $display("FAIL tmo_flag: got err=%b busy=%b, expected 1 0", err_timeout, busy);
    end
    extra = 0;
    repeat (5) begin
      if (wb_cyc_o) extra++;
      step();
    end
    tests++;
    if (extra != 0 || pushed.size() != 0) begin
      fails++;
      $display("FAIL tmo_abort: got extra cyc=%0d pushes=%0d, expected 0 0", extra, pushed.size());
    end
    clear_logs();
    ack_fixed = 0;
    data_q.push_back(8'hA5);
    issue(32'h8000_4400);
    wait_idle(50, 1'b0, n);
    tests++;
    if (n < 0 || pushed.size() != 1 || pushed[0] !== 32'h0000_44A5 || err_timeout !== 1'b1) begin
      fails++;
      $display("FAIL tmo_recover: got pushes=%0d word=%h err=%b, expected 1 000044a5 1",
               pushed.size(), pushed[0], err_timeout);
    end
  endtask

  task automatic test_ack_at_terminal();
    int n;
    do_reset();
    clear_logs();
    ack_fixed = int'(TMO) - 1;
    data_q.push_back(8'h3C);
    issue(32'h8000_7700);
    wait_idle(100, 1'b0, n);
    tests++;
    if (n < 0 || pushed.size() != 1 || pushed[0] !== 32'h0000_773C || err_timeout !== 1'b0) begin
      fails++;
      $display("FAIL ack_tc: got pushes=%0d word=%h err=%b, expected 1 0000773c 0",
               pushed.size(), pushed[0], err_timeout);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    clear_logs();
    ack_fixed = 0;
    issue(32'h4000_1234);
    step();
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL b2b_idle: got busy=%b, expected 0", busy);
    end
    data_q.push_back(8'h99);
    issue(32'h8000_5600);
    tests++;
    if ({wb_cyc_o, wb_we_o, wb_adr_o, cmd_dropped} !== {2'b10, 8'h56, 1'b0}) begin
      fails++;
      $display("FAIL b2b_accept: got cyc=%b we=%b adr=%h drop=%b, expected 1 0 56 0",
               wb_cyc_o, wb_we_o, wb_adr_o, cmd_dropped);
    end
    wait_idle(50, 1'b0, n);
    tests++;
    if (n < 0 || pushed.size() != 1 || pushed[0] !== 32'h0000_5699 ||
        wr_log.size() != 1 || wr_log[0] !== 16'h1234) begin
      fails++;
      $display("FAIL b2b_data: got pushes=%0d word=%h writes=%0d, expected 1 00005699 1",
               pushed.size(), pushed[0], wr_log.size());
    end
  endtask

  task automatic test_drop_and_reset();
    int n;
    int d;
    int k;
    int extra;
    do_reset();
    clear_logs();
    ack_fixed = 2;
    issue(32'hC300_0900);
    step();
    issue(32'h4000_AAAA);
    tests++;
    if (cmd_dropped !== 1'b1) begin
      fails++;
      $display("FAIL drop_flag: got %b expected 1", cmd_dropped);
    end
    wait_idle(200, 1'b0, n);
    build_expect(2'b11, 6'd3, 8'h09);
    d = count_diff();
    tests++;
    if (n < 0 || d != 0 || wr_log.size() != 0) begin
      fails++;
      $display("FAIL drop_orig: got n=%0d pushes=%0d diffs=%0d writes=%0d, expected 4 pushes 0 writes",
               n, pushed.size(), d, wr_log.size());
    end
    clear_logs();
    ack_fixed = 1;
    issue(32'hC700_0B00);
    k = 0;
    while (pushed.size() < 2 && k < 200) begin
      step();
      k++;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests++;
    if (k >= 200 || {busy, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, fifo_wr_en, fifo_din,
                     last_write, err_timeout, cmd_dropped} !== '0) begin
      fails++;
      $display("FAIL mid_reset: got k=%0d busy=%b cyc=%b we=%b adr=%h wr=%b din=%h last=%h err=%b drop=%b, expected all 0",
               k, busy, wb_cyc_o, wb_we_o, wb_adr_o, fifo_wr_en, fifo_din, last_write,
               err_timeout, cmd_dropped);
    end
    extra = 0;
    repeat (4) begin
      step();
      if (wb_cyc_o || busy) extra++;
    end
    tests++;
    if (extra != 0) begin
      fails++;
      $display("FAIL post_reset: got %0d active cycles, expected 0", extra);
    end
  endtask

  initial begin
    rst       = 1'b1;
    cmd_word  = 32'h0;
    cmd_trig  = 1'b0;
    fifo_full = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_burst();
    test_backpressure();
    test_random();
    test_timeout();
    test_ack_at_terminal();
    test_back_to_back();
    test_drop_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
